// File: rtl/adder_arbiter.sv
// adder_arbiter: shares one WIDTH-bit adder among NREQ requesters.
// Round-robin arbitration feeds a one-deep registered output buffer with backpressure.
//   clk, rst_n            clock and asynchronous active-low reset
//   req_valid/req_ready   per-requester handshake (req_ready is one-hot or zero)
//   req_a/req_b           operands; requester i occupies bits [i*WIDTH +: WIDTH]
//   rsp_valid/rsp_ready   response handshake
//   rsp_c/rsp_carry       {carry, sum} of A+B, computed at WIDTH+1 bits
//   rsp_id                index of the requester that produced the response
// NREQ must lie in 2..16, and 2**IDW must be at least NREQ.

// Per-requester term: is this requester valid and at or above the round-robin pointer?
module adder_arbiter_req #(
  parameter int IDW = 2,
  parameter int IDX = 0
) (
  input  logic [IDW-1:0] rr_ptr,
  input  logic           req_valid,
  output logic           hi_valid
);
  localparam logic [IDW-1:0] MY_IDX = IDW'(IDX);
  assign hi_valid = req_valid && (MY_IDX >= rr_ptr);
endmodule

module adder_arbiter #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_c,
  output logic                  rsp_carry,
  output logic [IDW-1:0]        rsp_id
);
  typedef enum logic {EMPTY, FULL} state_t;

  typedef struct packed {
    logic             carry;
    logic [WIDTH-1:0] c;
    logic [IDW-1:0]   id;
  } rsp_t;

  // Packed views: element i is exactly bits [i*WIDTH +: WIDTH] of the flat port.
  logic [NREQ-1:0][WIDTH-1:0] a_arr, b_arr;
  assign a_arr = req_a;
  assign b_arr = req_b;

  state_t          state_q, state_d;
  rsp_t            rsp_q;
  logic [IDW-1:0]  rr_ptr;
  logic [NREQ-1:0] hi_valid;
  logic [IDW-1:0]  gnt_idx;
  logic            gnt_any, can_accept, accept;
  logic [WIDTH:0]  sum;

  for (genvar i = 0; i < NREQ; i++) begin : g_req
    adder_arbiter_req #(.IDW(IDW), .IDX(i)) u_req (
      .rr_ptr   (rr_ptr),
      .req_valid(req_valid[i]),
      .hi_valid (hi_valid[i])
    );
  end

  // Two-pass priority search. The lowest valid index at or above rr_ptr wins.
  // If no such index exists, the search wraps to the lowest valid index overall.
  // Each loop runs downward, so the last assignment is the lowest set index.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        gnt_any = 1'b1;
        gnt_idx = IDW'(i);
      end
    end
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (hi_valid[i]) gnt_idx = IDW'(i);
    end
  end

  assign can_accept = (state_q == EMPTY) || rsp_ready;
  assign accept     = can_accept && gnt_any;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (accept && (gnt_idx == IDW'(i))) req_ready[i] = 1'b1;
    end
  end

  assign sum = {1'b0, a_arr[gnt_idx]} + {1'b0, b_arr[gnt_idx]};

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL:    if (rsp_ready && !accept) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      rsp_q   <= '0;
      rr_ptr  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        rsp_q  <= '{carry: sum[WIDTH], c: sum[WIDTH-1:0], id: gnt_idx};
        rr_ptr <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
      end
    end
  end

  assign rsp_valid = (state_q == FULL);
  assign rsp_c     = rsp_q.c;
  assign rsp_carry = rsp_q.carry;
  assign rsp_id    = rsp_q.id;
endmodule

// File: tb/tb_adder_arbiter.sv
module tb_adder_arbiter;
  localparam int WIDTH = 32;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;

  logic                       clk, rst_n, rsp_valid, rsp_ready, rsp_carry;
  logic [NREQ-1:0]            req_valid, req_ready;
  logic [NREQ-1:0][WIDTH-1:0] a_arr, b_arr;
  logic [WIDTH-1:0]           rsp_c;
  logic [IDW-1:0]             rsp_id;

  int checks = 0;
  int failures = 0;
  logic [WIDTH+IDW:0] exp_q[$];   // {carry, c, id}

  adder_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(a_arr), .req_b(b_arr), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_c(rsp_c), .rsp_carry(rsp_carry), .rsp_id(rsp_id)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic carry, input logic [WIDTH-1:0] c, input logic [IDW-1:0] id);
    exp_q.push_back({carry, c, id});
  endtask

  // Monitor: every handshake on the response channel consumes one scoreboard entry.
  always @(negedge clk) begin
    if (rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", {rsp_carry, rsp_c, rsp_id}, 64'hdead);
      end else begin
        logic [WIDTH+IDW:0] e;
        e = exp_q.pop_front();
        chk("rsp", {rsp_carry, rsp_c, rsp_id}, e);
      end
    end
  end

  initial begin
    rst_n = 0; req_valid = '0; a_arr = '0; b_arr = '0; rsp_ready = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_c", rsp_c, 0);
    chk("rst_id", rsp_id, 0);
    chk("rst_ready", req_ready, 0);
    rst_n = 1;
    repeat (2) begin
      @(negedge clk);
      chk("idle_valid", rsp_valid, 0);
      chk("idle_ready", req_ready, 0);
      chk("idle_c", rsp_c, 0);
    end
    step();

    // Single request on requester 1
    a_arr[1] = 5; b_arr[1] = 7; req_valid = 4'b0010;
    @(negedge clk); chk("single_ready", req_ready, 4'b0010);
    push(0, 12, 1);
    step(); req_valid = '0;
    step();
    @(negedge clk); chk("single_empty", rsp_valid, 0);

    // Wrap-around on requester 0 (rr_ptr=2, so the search wraps)
    step();
    a_arr[0] = 32'hFFFF_FFFF; b_arr[0] = 32'h2; req_valid = 4'b0001;
    @(negedge clk); chk("wrap_ready", req_ready, 4'b0001);
    push(1, 32'h1, 0);
    step();
    // Requester 3 next so that rr_ptr returns to 0
    a_arr[3] = 10; b_arr[3] = 20; req_valid = 4'b1000;
    @(negedge clk); chk("r3_ready", req_ready, 4'b1000);
    push(0, 30, 3);
    step();

    // Round-robin with every requester valid
    for (int i = 0; i < NREQ; i++) begin a_arr[i] = i; b_arr[i] = 100; end
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); chk("rr_ready", req_ready, 4'b0001 << (k % 4));
      push(0, 100 + (k % 4), IDW'(k % 4));
      step();
    end
    req_valid = '0;
    step();   // drain the last round-robin result; state EMPTY, rr_ptr=0

    // Backpressure
    rsp_ready = 0;
    a_arr[1] = 1000; b_arr[1] = 1; req_valid = 4'b0010;
    @(negedge clk); chk("bp_first_ready", req_ready, 4'b0010);
    push(0, 1001, 1);
    step();
    a_arr[2] = 7; b_arr[2] = 8; req_valid = 4'b0100;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("bp_ready0", req_ready, 0);
      chk("bp_valid", rsp_valid, 1);
      chk("bp_c", rsp_c, 1001);
      chk("bp_id", rsp_id, 1);
      step();
    end
    rsp_ready = 1;
    @(negedge clk); chk("bp_same_cycle", req_ready, 4'b0100);
    push(0, 15, 2);
    step(); req_valid = '0;
    @(negedge clk); chk("bp_no_bubble", rsp_valid, 1);
    step();

    // Reset mid-operation (rr_ptr=3; only requester 0 valid)
    rsp_ready = 0;
    a_arr[0] = 1; b_arr[0] = 1; req_valid = 4'b0001;
    @(negedge clk); chk("mid_ready", req_ready, 4'b0001);
    step(); req_valid = '0;
    chk("mid_full", rsp_valid, 1);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_valid", rsp_valid, 0);
    chk("mid_rst_c", rsp_c, 0);
    step();
    rst_n = 1; rsp_ready = 1;
    a_arr[2] = 2; b_arr[2] = 3; a_arr[3] = 4; b_arr[3] = 5; req_valid = 4'b1100;
    @(negedge clk); chk("post_rst_grant", req_ready, 4'b0100);
    push(0, 5, 2);
    step();
    @(negedge clk); chk("post_rst_grant2", req_ready, 4'b1000);
    push(0, 9, 3);
    step(); req_valid = '0;
    repeat (3) step();

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
